// File: rtl/pwm_wb_regs_if.sv
// Wishbone-classic slave bus bundle between the user-area port and the PWM register bank.
interface pwm_wb_regs_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/pwm_wb_regs.sv
// PWM register bank: decodes Wishbone accesses, stages period/duty values and commits them
// to the active shadows only at each channel's period boundary; sticky period-end IRQs.
module pwm_wb_regs #(
    parameter int          CHANNELS  = 4,
    parameter int          WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    pwm_wb_regs_if.slave              wbs,
    input  logic [CHANNELS-1:0]       period_end_i,
    output logic [CHANNELS-1:0]       enable_o,
    output logic [CHANNELS*WIDTH-1:0] period_o,
    output logic [CHANNELS*WIDTH-1:0] duty_o,
    output logic                      irq_o
);
    localparam logic [31:0] ID_VALUE = 32'h5057_4D01;

    logic                ack_q, ack_d;
    logic [31:0]         datOut_q, datOut_d;
    logic [CHANNELS-1:0] enable_q, enable_d;
    logic [CHANNELS-1:0] irqEn_q, irqEn_d;
    logic [CHANNELS-1:0] status_q, status_d;
    logic [WIDTH-1:0]    periodStg_q [CHANNELS];
    logic [WIDTH-1:0]    periodStg_d [CHANNELS];
    logic [WIDTH-1:0]    dutyStg_q   [CHANNELS];
    logic [WIDTH-1:0]    dutyStg_d   [CHANNELS];
    logic [WIDTH-1:0]    periodShd_q [CHANNELS];
    logic [WIDTH-1:0]    periodShd_d [CHANNELS];
    logic [WIDTH-1:0]    dutyShd_q   [CHANNELS];
    logic [WIDTH-1:0]    dutyShd_d   [CHANNELS];

    logic                hit, access, wrEn, rdEn;
    logic [5:0]          wordOff;
    logic [1:0]          unusedAdr;
    logic [31:0]         rdData;
    logic [CHANNELS-1:0] statusClr;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  sel);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[b*8 +: 8] = sel[b] ? newVal[b*8 +: 8] : oldVal[b*8 +: 8];
        end
        return result;
    endfunction

    // A held strobe is acked every other cycle, so only the first cycle of a request acts.
    assign hit       = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign access    = hit & ~ack_q;
    assign wrEn      = access & wbs.wbs_we_i;
    assign rdEn      = access & ~wbs.wbs_we_i;
    assign wordOff   = wbs.wbs_adr_i[7:2];
    assign unusedAdr = wbs.wbs_adr_i[1:0];
    assign ack_d     = access;

    always_comb begin
        rdData = '0;
        if (wordOff == 6'd0) begin
            rdData[CHANNELS-1:0] = enable_q;
            rdData[8 +: CHANNELS] = irqEn_q;
        end else if (wordOff == 6'd1) begin
            rdData = 32'(status_q);
        end else if (wordOff == 6'd2) begin
            rdData = ID_VALUE;
        end
        for (int n = 0; n < CHANNELS; n++) begin
            if (wordOff == 6'(4 + 2*n)) rdData = 32'(periodStg_q[n]);
            if (wordOff == 6'(5 + 2*n)) rdData = 32'(dutyStg_q[n]);
        end
        datOut_d = rdEn ? rdData : '0;
    end

    // Register writes; staging fields keep only their low WIDTH bits after the byte merge.
    always_comb begin
        enable_d    = enable_q;
        irqEn_d     = irqEn_q;
        statusClr   = '0;
        periodStg_d = periodStg_q;
        dutyStg_d   = dutyStg_q;
        if (wrEn) begin
            if (wordOff == 6'd0) begin
                if (wbs.wbs_sel_i[0]) enable_d = wbs.wbs_dat_i[CHANNELS-1:0];
                if (wbs.wbs_sel_i[1]) irqEn_d  = wbs.wbs_dat_i[8 +: CHANNELS];
            end
            if (wordOff == 6'd1) begin
                statusClr = wbs.wbs_dat_i[CHANNELS-1:0] & {CHANNELS{wbs.wbs_sel_i[0]}};
            end
            for (int n = 0; n < CHANNELS; n++) begin
                if (wordOff == 6'(4 + 2*n)) begin
                    periodStg_d[n] = WIDTH'(mergeBytes(32'(periodStg_q[n]), wbs.wbs_dat_i, wbs.wbs_sel_i));
                end
                if (wordOff == 6'(5 + 2*n)) begin
                    dutyStg_d[n] = WIDTH'(mergeBytes(32'(dutyStg_q[n]), wbs.wbs_dat_i, wbs.wbs_sel_i));
                end
            end
        end
        status_d = (status_q & ~statusClr) | period_end_i;
    end

    // Disabled channels follow staging continuously; enabled ones commit only at period end.
    always_comb begin
        periodShd_d = periodShd_q;
        dutyShd_d   = dutyShd_q;
        for (int n = 0; n < CHANNELS; n++) begin
            if (!enable_q[n] || period_end_i[n]) begin
                periodShd_d[n] = periodStg_q[n];
                dutyShd_d[n]   = dutyStg_q[n];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            datOut_q <= '0;
            enable_q <= '0;
            irqEn_q  <= '0;
            status_q <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                periodStg_q[n] <= '0;
                dutyStg_q[n]   <= '0;
                periodShd_q[n] <= '0;
                dutyShd_q[n]   <= '0;
            end
        end else begin
            ack_q       <= ack_d;
            datOut_q    <= datOut_d;
            enable_q    <= enable_d;
            irqEn_q     <= irqEn_d;
            status_q    <= status_d;
            periodStg_q <= periodStg_d;
            dutyStg_q   <= dutyStg_d;
            periodShd_q <= periodShd_d;
            dutyShd_q   <= dutyShd_d;
        end
    end

    always_comb begin
        period_o = '0;
        duty_o   = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            period_o[n*WIDTH +: WIDTH] = periodShd_q[n];
            duty_o[n*WIDTH +: WIDTH]   = dutyShd_q[n];
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = datOut_q;
    assign enable_o      = enable_q;
    assign irq_o         = |(status_q & irqEn_q);
endmodule

// File: tb/tb_pwm_wb_regs.sv
// Self-checking bench for pwm_wb_regs: read data is scoreboarded (expected values queued at
// request time, popped by a monitor on each read ack); outputs are checked against constants.
module tb_pwm_wb_regs;
    localparam int          CHANNELS = 4;
    localparam int          WIDTH    = 16;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] ID_VAL   = 32'h5057_4D01;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } expItem_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [CHANNELS-1:0]       periodEnd;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS*WIDTH-1:0] period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic                      irq;

    int       checkCount  = 0;
    int       errorCount  = 0;
    int       lastLatency = 0;
    expItem_t expQ[$];

    pwm_wb_regs_if wbs ();

    pwm_wb_regs #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs         (wbs),
        .period_end_i(periodEnd),
        .enable_o    (enable),
        .period_o    (period),
        .duty_o      (duty),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: every read ack pops the oldest expected value.
    always @(negedge clk) begin
        if (wbs.wbs_ack_o === 1'b1 && wbs.wbs_we_i === 1'b0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRdAck", 32'd1, 32'd0);
            end else begin
                expItem_t item;
                item = expQ.pop_front();
                checkOutput(item.tag, wbs.wbs_dat_o, item.data);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [7:0] off, input logic [31:0] data,
                                 input logic [3:0] sel, input logic [CHANNELS-1:0] pulse,
                                 input logic [31:0] expRd, input string tag);
        int waited = 0;
        bit gotAck = 1'b0;
        if (!we) expQ.push_back('{tag, expRd});
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_adr_i = BASE | {24'h0, off};
        wbs.wbs_dat_i = data;
        wbs.wbs_sel_i = sel;
        periodEnd     = pulse;
        while (!gotAck && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
            periodEnd = '0;
            gotAck = (wbs.wbs_ack_o === 1'b1);
        end
        lastLatency   = waited;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        if (!gotAck) begin
            checkOutput({tag, "_ackTimeout"}, 32'd0, 32'd1);
            if (!we && expQ.size() > 0) expQ.delete(expQ.size() - 1);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_ackDrop"}, 32'(wbs.wbs_ack_o), 32'd0);
        if (!we) checkOutput({tag, "_datIdle"}, wbs.wbs_dat_o, 32'd0);
    endtask

    task automatic wbWrite(input logic [7:0] off, input logic [31:0] data, input logic [3:0] sel);
        applyStimulus(1'b1, off, data, sel, '0, 32'd0, "wr");
    endtask

    task automatic wbRead(input logic [7:0] off, input logic [31:0] expRd, input string tag);
        applyStimulus(1'b0, off, 32'd0, 4'hF, '0, expRd, tag);
    endtask

    task automatic pulseEnd(input logic [CHANNELS-1:0] mask);
        periodEnd = mask;
        @(posedge clk);
        #1;
        periodEnd = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int ackCount;
        rst           = 1'b1;
        periodEnd     = '0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_sel_i = 4'h0;
        wbs.wbs_adr_i = 32'h0;
        wbs.wbs_dat_i = 32'h0;
        @(posedge clk);
        #1;

        // Reset held two cycles with a write in flight: no ack, everything cleared.
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_adr_i = BASE;
        wbs.wbs_dat_i = 32'hFFFF_FFFF;
        wbs.wbs_sel_i = 4'hF;
        periodEnd     = '1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rstNoAck", 32'(wbs.wbs_ack_o), 32'd0);
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        periodEnd     = '0;
        rst           = 1'b0;
        checkOutput("rstEnable", 32'(enable), 32'd0);
        checkOutput("rstPeriod", period[31:0], 32'd0);
        checkOutput("rstDuty", duty[31:0], 32'd0);
        checkOutput("rstIrq", 32'(irq), 32'd0);
        checkOutput("rstDat", wbs.wbs_dat_o, 32'd0);

        wbRead(8'h08, ID_VAL, "idRead");
        checkOutput("idLatency", 32'(lastLatency), 32'd1);
        wbRead(8'h00, 32'h0, "ctrlAfterRst");
        wbRead(8'h04, 32'h0, "statusAfterRst");

        // Byte enables and WIDTH truncation on disabled channel 0.
        wbWrite(8'h10, 32'hAABB_CCDD, 4'b0001);
        checkOutput("periodShadowCh0", 32'(period[15:0]), 32'h0000_00DD);
        wbRead(8'h10, 32'h0000_00DD, "periodStgSel");
        wbWrite(8'h14, 32'hAABB_CCDD, 4'b0110);
        checkOutput("dutyShadowCh0", 32'(duty[15:0]), 32'h0000_CC00);
        wbRead(8'h14, 32'h0000_CC00, "dutyStgSel");

        // Shadow synchronisation on enabled channel 1.
        wbWrite(8'h00, 32'h0000_0002, 4'hF);
        checkOutput("enableCh1", 32'(enable), 32'h2);
        wbWrite(8'h1C, 32'd100, 4'hF);
        checkOutput("dutyHeldCh1", 32'(duty[31:16]), 32'd0);
        pulseEnd(4'b0010);
        checkOutput("dutyLoadedCh1", 32'(duty[31:16]), 32'd100);
        checkOutput("irqMasked", 32'(irq), 32'd0);
        applyStimulus(1'b1, 8'h1C, 32'd200, 4'hF, 4'b0010, 32'd0, "dutyWrPulse");
        checkOutput("dutyOldLoadedCh1", 32'(duty[31:16]), 32'd100);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("dutyFrozenCh1", 32'(duty[31:16]), 32'd100);
        pulseEnd(4'b0010);
        checkOutput("dutyNewLoadedCh1", 32'(duty[31:16]), 32'd200);
        checkOutput("periodCh1", 32'(period[31:16]), 32'd0);
        wbRead(8'h1C, 32'd200, "dutyStgCh1");

        // Disabling makes the shadow transparent again.
        wbWrite(8'h00, 32'h0000_0000, 4'hF);
        wbWrite(8'h1C, 32'd300, 4'hF);
        checkOutput("dutyTrackCh1", 32'(duty[31:16]), 32'd300);

        // Interrupts on channel 2.
        wbWrite(8'h04, 32'h0000_000F, 4'hF);
        wbRead(8'h04, 32'h0, "statusCleared");
        wbWrite(8'h00, 32'h0000_0402, 4'hF);
        wbRead(8'h00, 32'h0000_0402, "ctrlRead");
        pulseEnd(4'b0100);
        checkOutput("irqRise", 32'(irq), 32'd1);
        wbRead(8'h04, 32'h4, "statusSet");
        applyStimulus(1'b1, 8'h04, 32'h4, 4'hF, 4'b0100, 32'd0, "w1cWithPulse");
        checkOutput("irqHeld", 32'(irq), 32'd1);
        wbRead(8'h04, 32'h4, "statusSetWins");
        wbWrite(8'h04, 32'h4, 4'hF);
        checkOutput("irqFall", 32'(irq), 32'd0);
        wbRead(8'h04, 32'h0, "statusW1c");
        pulseEnd(4'b0001);
        checkOutput("irqCh0Masked", 32'(irq), 32'd0);
        wbRead(8'h04, 32'h1, "statusCh0");
        wbWrite(8'h04, 32'h1, 4'b0010);
        wbRead(8'h04, 32'h1, "statusW1cSel");
        wbWrite(8'h04, 32'h1, 4'b0001);
        wbRead(8'h04, 32'h0, "statusCh0Cleared");

        // Decode: unmapped offsets, ignored low address bits, out-of-window accesses.
        wbRead(8'h40, 32'h0, "unmappedRd");
        wbWrite(8'h40, 32'hFFFF_FFFF, 4'hF);
        wbRead(8'h0C, 32'h0, "gapRd");
        wbRead(8'h00, 32'h0000_0402, "ctrlAfterUnmapped");
        wbRead(8'h0A, ID_VAL, "idUnaligned");

        ackCount = 0;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_adr_i = BASE + 32'h100;
        wbs.wbs_dat_i = 32'h0;
        wbs.wbs_sel_i = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (wbs.wbs_ack_o === 1'b1) ackCount++;
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        checkOutput("oowNoAck", 32'(ackCount), 32'd0);
        wbRead(8'h00, 32'h0000_0402, "ctrlAfterOow");

        // Held strobe: acks alternate 1,0,1,0.
        expQ.push_back('{"heldRd0", ID_VAL});
        expQ.push_back('{"heldRd1", ID_VAL});
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_adr_i = BASE + 32'h08;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("heldAck", 32'(wbs.wbs_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        @(posedge clk);
        #1;

        // Undefined CTRL bits read back as zero.
        wbWrite(8'h00, 32'hFFFF_FFFF, 4'hF);
        checkOutput("enableAll", 32'(enable), 32'hF);
        wbRead(8'h00, 32'h0000_0F0F, "ctrlMasked");

        checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/pwm_wb_regs.md
# pwm_wb_regs

Wishbone-classic slave register bank that sits between the user-area Wishbone port and the PWM generator channels inside the PWM user project. It decodes management-SoC accesses, holds per-channel staging and shadow period/duty registers, and transfers staged values to the active shadows only at each channel's period boundary so waveforms never glitch. It also collects period-end events into a sticky status register and drives the user interrupt.

## Interface
Parameters:
- CHANNELS, 4, number of PWM channels (1..8)
- WIDTH, 16, period/duty width in bits (1..32)
- BASE_ADDR, 32'h3000_0000, 256-byte window base; only adr[31:8] compared

Ports:
- wb_clk_i  in  1  single clock; all logic rising-edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- period_end_i  in  CHANNELS  one-cycle pulse per channel at its counter wrap
- enable_o  out  CHANNELS  channel enables (CTRL[CHANNELS-1:0])
- period_o  out  CHANNELS*WIDTH  active (shadow) periods, channel n at [n*WIDTH +: WIDTH]
- duty_o  out  CHANNELS*WIDTH  active (shadow) duties, same packing
- irq_o  out  1  interrupt, level

## Operation
- Select: hit = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]); adr[1:0] ignored.
- Register map (offset = adr[7:0]):
  - 0x00 CTRL RW: [CHANNELS-1:0] enable, [8+CHANNELS-1:8] irq enable; other bits read 0.
  - 0x04 STATUS W1C: [CHANNELS-1:0] sticky period-end flags.
  - 0x08 ID RO: 32'h5057_4D01.
  - 0x10+8n PERIOD_STG n RW; 0x14+8n DUTY_STG n RW (n < CHANNELS).
  - Any other in-window offset: acked, reads 0, writes ignored.
- Writes honour wbs_sel_i per byte; bits above WIDTH (or above defined fields) dropped; reads zero-extended.
- Shadow load for channel n, on a clock edge: if enable[n]==0, shadow <= staging every cycle (transparent); else shadow <= staging only when period_end_i[n]==1. Loads use the staging value held before that edge.
- STATUS[n] set when period_end_i[n]==1 regardless of enable; cleared by writing 1 to that bit. Set and clear in the same cycle: set wins.
- irq_o = |(STATUS & IRQ_EN), from registers.
- Duty >= period stored unmodified; interpretation is the generator's.
- Out-of-window accesses: no ack, no side effects (upstream decode guarantees termination).

## Timing
- Reset (wb_rst_i high at an edge): CTRL, STATUS, all staging and shadow registers = 0; wbs_ack_o = 0, wbs_dat_o = 0, irq_o = 0, enable_o = 0, period_o = duty_o = 0. Reset overrides any bus access or period_end_i in that cycle; an in-flight access is dropped (no ack).
- Ack: wbs_ack_o <= hit & ~wbs_ack_o; one-cycle pulse at the edge after request; held stb yields ack every other cycle (no back-to-back acks). Ack never asserted while cyc or stb low in the request cycle.
- Write takes effect at the same edge that raises ack; read data registered at that edge; wbs_dat_o returns to 0 the cycle after ack.
- Staging write to channel n in the cycle period_end_i[n] pulses: shadow loads the old value; new value goes active at the next period end.
- CTRL enable write 1->0: shadows track staging from the next edge; 0->1: shadows freeze at current staging value.
- irq_o rises one cycle after period_end_i edge (when enabled); falls one cycle after the W1C ack edge.

## Test plan
- Reset: hold wb_rst_i 2 cycles mid-write -> no ack, all outputs 0, read ID returns 32'h5057_4D01 with ack exactly 1 cycle after stb.
- Byte enables: write 32'hAABB_CCDD to PERIOD_STG0 with sel=4'b0001 (WIDTH=16) -> readback 32'h0000_00DD; channel disabled so period_o[15:0]=16'h00DD next cycle.
- Shadow sync: enable ch1, write DUTY_STG1=100 -> duty_o ch1 unchanged until period_end_i[1] pulse, then 100 at the following cycle; write 200 coincident with pulse -> 100 loads, 200 loads only at next pulse.
- IRQ: IRQ_EN ch2=1, pulse period_end_i[2] -> STATUS=4, irq_o=1 next cycle; write STATUS=4 with simultaneous pulse -> STATUS stays 4, irq_o stays 1; later write 4 alone -> irq_o 0.
- Decode: access adr=BASE+0x40 -> ack, read 0, no state change; adr outside window -> no ack for 10 cycles; held stb -> ack pattern 1,0,1,0.
